// File: rtl/regfile_dump.sv
// Debug-side register file walker: reads a contiguous (optionally wrapping) address
// range through the debug read port and streams (address, data) beats on valid/ready.
module regfile_dump #(
    parameter int NUM_REGS   = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  start_i,
    input  logic [ADDR_WIDTH-1:0] first_addr_i,
    input  logic [ADDR_WIDTH-1:0] last_addr_i,
    input  logic                  abort_i,
    output logic [ADDR_WIDTH-1:0] dbg_addr_o,
    input  logic [DATA_WIDTH-1:0] dbg_data_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [ADDR_WIDTH-1:0] out_addr_o,
    output logic [DATA_WIDTH-1:0] out_data_o,
    output logic                  out_last_o,
    output logic                  busy_o,
    output logic                  done_o
);

    typedef enum logic [1:0] {IDLE, READ, SEND, DONE} state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] cur_q, cur_d;
    logic [ADDR_WIDTH-1:0] end_q, end_d;
    logic [ADDR_WIDTH-1:0] out_addr_q, out_addr_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic                  out_last_q, out_last_d;
    logic                  out_valid_q, busy_q, done_q;
    logic [ADDR_WIDTH-1:0] cur_inc;

    // Wrap explicitly so a non-power-of-two NUM_REGS still walks modulo NUM_REGS.
    assign cur_inc = (cur_q == ADDR_WIDTH'(NUM_REGS - 1)) ? '0 : cur_q + 1'b1;

    always_comb begin
        state_d    = state_q;
        cur_d      = cur_q;
        end_d      = end_q;
        out_addr_d = out_addr_q;
        out_data_d = out_data_q;
        out_last_d = out_last_q;
        case (state_q)
            IDLE: begin
                if (start_i && !abort_i) begin
                    cur_d   = first_addr_i;
                    end_d   = last_addr_i;
                    state_d = READ;
                end
            end
            READ: begin
                if (abort_i) begin
                    state_d = IDLE;
                end else begin
                    out_addr_d = cur_q;
                    out_data_d = dbg_data_i;
                    out_last_d = (cur_q == end_q);
                    state_d    = SEND;
                end
            end
            SEND: begin
                // Abort wins over the next state even when a transfer coincides.
                if (abort_i) begin
                    state_d = IDLE;
                end else if (out_ready_i) begin
                    if (out_last_q) begin
                        state_d = DONE;
                    end else begin
                        cur_d   = cur_inc;
                        state_d = READ;
                    end
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            cur_q       <= '0;
            end_q       <= '0;
            out_addr_q  <= '0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_q       <= cur_d;
            end_q       <= end_d;
            out_addr_q  <= out_addr_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            out_valid_q <= (state_d == SEND);
            busy_q      <= (state_d != IDLE);
            done_q      <= (state_d == DONE);
        end
    end

    assign dbg_addr_o  = cur_q;
    assign out_valid_o = out_valid_q;
    assign out_addr_o  = out_addr_q;
    assign out_data_o  = out_data_q;
    assign out_last_o  = out_last_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;

endmodule

// File: tb/tb_regfile_dump.sv
// Randomized self-checking bench for regfile_dump: a behavioural register file and
// a queue of expected beats derived from the range rules.
module tb_regfile_dump;

    localparam int NR = 32;
    localparam int AW = 5;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] first_addr = '0;
    logic [AW-1:0] last_addr = '0;
    logic          abort = 1'b0;
    logic [AW-1:0] dbg_addr;
    logic [DW-1:0] dbg_data;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [AW-1:0] out_addr;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic          busy;
    logic          done;

    logic [DW-1:0] regs [NR];
    int            n_checks = 0;
    int            n_fail = 0;

    assign dbg_data = regs[dbg_addr];

    always #5 clk = ~clk;

    regfile_dump #(.NUM_REGS(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start),
        .first_addr_i(first_addr), .last_addr_i(last_addr), .abort_i(abort),
        .dbg_addr_o(dbg_addr), .dbg_data_i(dbg_data),
        .out_valid_o(out_valid), .out_ready_i(out_ready),
        .out_addr_o(out_addr), .out_data_o(out_data), .out_last_o(out_last),
        .busy_o(busy), .done_o(done)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"}, 64'(out_valid), 0);
        check({tag, "_addr"}, 64'(out_addr), 0);
        check({tag, "_data"}, 64'(out_data), 0);
        check({tag, "_last"}, 64'(out_last), 0);
        check({tag, "_busy"}, 64'(busy), 0);
        check({tag, "_done"}, 64'(done), 0);
        check({tag, "_dbg"}, 64'(dbg_addr), 0);
    endtask

    // One full dump; stalls = forced ready=0 cycles in SEND, rnd = random ready,
    // inject = pulse start with a different range while busy.
    task automatic run_dump(input int first, input int last, input int stalls,
                            input bit rnd, input bit inject);
        int            q_addr[$];
        int            n, cyc, busy_cnt, done_cnt, stall_cnt, stalls_left;
        bit            seen_done, held;
        logic [AW-1:0] h_addr;
        logic [DW-1:0] h_data;
        logic          h_last;
        n = ((last - first + NR) % NR) + 1;
        for (int k = 0; k < n; k++) q_addr.push_back((first + k) % NR);
        @(negedge clk);
        start = 1'b1; first_addr = AW'(first); last_addr = AW'(last); out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0; busy_cnt = 0; done_cnt = 0; stall_cnt = 0; stalls_left = stalls;
        seen_done = 0; held = 0; h_addr = '0; h_data = '0; h_last = 1'b0;
        while (!seen_done && cyc < 400) begin
            if (busy) busy_cnt++;
            if (done) begin done_cnt++; seen_done = 1; end
            if (cyc == 0) check("lat_read_valid", 64'(out_valid), 0);
            if (cyc == 1) check("lat_send_valid", 64'(out_valid), 1);
            if (held) begin
                check("stall_valid", 64'(out_valid), 1);
                check("stall_addr", 64'(out_addr), 64'(h_addr));
                check("stall_data", 64'(out_data), 64'(h_data));
                check("stall_last", 64'(out_last), 64'(h_last));
                held = 0;
            end
            if (busy && !out_valid && !done && q_addr.size() > 0)
                check("dbg_addr_read", 64'(dbg_addr), 64'(q_addr[0]));
            if (inject && cyc == 2) begin
                start = 1'b1; first_addr = 5'd5; last_addr = 5'd9;
            end else begin
                start = 1'b0;
            end
            if (out_valid && stalls_left > 0) begin
                out_ready = 1'b0; stalls_left--;
            end else begin
                out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            if (out_valid && out_ready) begin
                if (q_addr.size() == 0) begin
                    check("extra_beat", 64'(out_addr), 64'hFFFF);
                end else begin
                    check("beat_addr", 64'(out_addr), 64'(q_addr[0]));
                    check("beat_data", 64'(out_data), 64'(regs[q_addr[0]]));
                    check("beat_last", 64'(out_last), 64'(q_addr.size() == 1));
                    void'(q_addr.pop_front());
                end
            end else if (out_valid) begin
                held = 1; h_addr = out_addr; h_data = out_data; h_last = out_last;
                stall_cnt++;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0; out_ready = 1'b1;
        check("done_seen", 64'(seen_done), 1);
        check("beats_missing", 64'(q_addr.size()), 0);
        check("busy_cycles", 64'(busy_cnt), 64'(2 * n + 1 + stall_cnt));
        check("dbg_addr_idle", 64'(dbg_addr), 64'(last));
        for (int k = 0; k < 3; k++) begin
            check("post_busy", 64'(busy), 0);
            check("post_done", 64'(done), 0);
            check("post_valid", 64'(out_valid), 0);
            @(negedge clk);
        end
        $display("dump first=%0d last=%0d beats=%0d stalls=%0d busy=%0d dones=%0d",
                 first, last, n, stall_cnt, busy_cnt, done_cnt);
    endtask

    initial begin
        int beats, bound;
        for (int i = 0; i < NR; i++) regs[i] = 32'h100 + i;
        #2 rst_n = 1'b0;
        #1 check_all_zero("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        regs[7] = 32'hDEADBEEF;
        run_dump(7, 7, 0, 0, 0);
        regs[7] = 32'h107;
        run_dump(0, 31, 0, 0, 0);
        run_dump(30, 1, 0, 0, 0);
        run_dump(4, 6, 5, 0, 0);
        run_dump(0, 3, 0, 0, 1);

        // start together with abort in IDLE is ignored
        @(negedge clk);
        start = 1'b1; abort = 1'b1; first_addr = 5'd2; last_addr = 5'd4;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        check("start_abort_busy", 64'(busy), 0);

        // abort during the third beat's SEND with ready low
        start = 1'b1; first_addr = 5'd0; last_addr = 5'd7; out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0; beats = 0; bound = 0;
        while (bound < 50) begin
            if (out_valid && beats == 2) break;
            if (out_valid) beats++;
            @(negedge clk);
            bound++;
        end
        check("abort_reach_beat3", 64'(beats), 2);
        check("abort_beat3_addr", 64'(out_addr), 2);
        out_ready = 1'b0; abort = 1'b1;
        @(negedge clk);
        abort = 1'b0; out_ready = 1'b1;
        check("abort_valid", 64'(out_valid), 0);
        check("abort_busy", 64'(busy), 0);
        for (int k = 0; k < 3; k++) begin
            check("abort_no_done", 64'(done), 0);
            @(negedge clk);
        end
        $display("abort at beat 3 done");

        // asynchronous reset mid-dump
        start = 1'b1; first_addr = 5'd10; last_addr = 5'd20; out_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        check("pre_reset_valid", 64'(out_valid), 1);
        #2 rst_n = 1'b0;
        #1 check_all_zero("midreset");
        @(negedge clk);
        rst_n = 1'b1; out_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("after_reset_done", 64'(done), 0);
            check("after_reset_valid", 64'(out_valid), 0);
        end
        $display("mid-dump reset done");
        run_dump(29, 2, 0, 0, 0);

        for (int t = 0; t < 10; t++) begin
            int f, l;
            for (int i = 0; i < NR; i++) regs[i] = $urandom;
            f = $urandom_range(0, NR - 1);
            l = $urandom_range(0, NR - 1);
            run_dump(f, l, $urandom_range(0, 3), 1, t[0]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_dump.md
# regfile_dump

Debug-side reader for the processor register file. On a start request it walks a contiguous, optionally wrapping, range of register addresses through the register file's debug read port. Each word is returned as an (address, data) beat on a valid/ready stream toward the debug/host link. The block only reads: it drives the debug read address and samples the combinational debug read data, and it never disturbs the pipeline's read or write ports.

## Interface
- NUM_REGS, 32, number of architectural registers; addresses wrap modulo NUM_REGS
- ADDR_WIDTH, 5, register address width (log2 NUM_REGS)
- DATA_WIDTH, 32, register data width

- clock  in  1  single system clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- start  in  1  request a dump; sampled only in IDLE
- first_addr  in  ADDR_WIDTH  first register of range, latched on accepted start
- last_addr  in  ADDR_WIDTH  last register of range, latched on accepted start
- abort  in  1  synchronous cancel of a dump in progress
- dbg_addr  out  ADDR_WIDTH  to register file debug read address
- dbg_data  in  DATA_WIDTH  from register file debug read data (combinational w.r.t. dbg_addr)
- out_valid  out  1  beat available
- out_ready  in  1  consumer accepts beat
- out_addr  out  ADDR_WIDTH  register address of current beat
- out_data  out  DATA_WIDTH  register value of current beat
- out_last  out  1  current beat is the final one of the range
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse after the final beat transfers

## Operation
- FSM states: IDLE, READ, SEND, DONE.
- IDLE: if start=1 and abort=0, latch cur<=first_addr and end<=last_addr, then go to READ. Otherwise stay.
- READ: dbg_addr=cur. At the rising edge, capture out_data<=dbg_data and out_addr<=cur, set out_last<=(cur==end), then go to SEND.
- SEND: out_valid=1. out_addr, out_data and out_last stay stable until the transfer (out_valid and out_ready both high at an edge).
  - Transfer with out_last=1: go to DONE.
  - Transfer with out_last=0: cur<=(cur+1) mod NUM_REGS, go to READ.
- DONE: done=1 for exactly one cycle, then IDLE.
- Range rules:
  - first_addr==last_addr: exactly one beat.
  - first_addr>last_addr: the walk wraps 31->0. Example: first 30, last 1 gives 30, 31, 0, 1.
  - Beat count is always ((last-first) mod NUM_REGS)+1, so 1..32 beats.
- Register 0 is read like any other register; no special casing.
- start while busy=1 is ignored; first_addr and last_addr are not re-latched.
- abort=1 in READ, SEND or DONE: go to IDLE at the next edge, out_valid<=0, no done pulse.
  - If abort and a transfer coincide in SEND, the beat counts as delivered, and abort still wins over the next state.
- abort=1 and start=1 together in IDLE: start is ignored.
- dbg_addr always equals cur, including in IDLE, where it holds its last value.
- Reset values, with reset low at any time including mid-dump:
  - state=IDLE
  - cur=0, dbg_addr=0
  - out_valid=0, out_addr=0, out_data=0, out_last=0
  - busy=0, done=0
  - Release from reset is synchronous to the next clock edge; no beat or done pulse is produced for the interrupted dump.

## Timing
- Start accepted at edge T: READ during cycle T..T+1, out_valid high from edge T+1.
- Throughput: one beat per 2 cycles with out_ready held high. An N-beat dump holds busy for 2N+1 cycles: N READ, N SEND, 1 DONE.
- Backpressure: each cycle with out_ready=0 in SEND adds one cycle; the outputs are frozen.
- dbg_data is sampled at the rising edge ending READ. The register file writes on the falling edge, so a write in the same cycle is visible in the captured value.
- done is asserted the cycle after the final transfer edge; busy falls together with done at the following edge.
- All outputs are registered except dbg_addr, which is the cur register directly.

## Test plan
- Single register: preload r7=0xDEADBEEF, start with first=7, last=7, ready=1.
  - Required: one beat addr=7, data=0xDEADBEEF, last=1.
  - Required: out_valid rises 1 cycle after the start edge; done pulses once; busy high for 3 cycles.
- Full dump: preload ri=0x100+i, first=0, last=31, ready=1.
  - Required: 32 beats in order, data 0x100..0x11F; last=1 only on addr 31; busy high 65 cycles.
- Wrap: first=30, last=1.
  - Required: beats at addrs 30, 31, 0, 1; last on addr 1.
- Backpressure: hold ready=0 for 5 cycles in SEND.
  - Required: valid, addr and data stable throughout; one extra cycle per stall; no beat dropped or duplicated.
- Abort/reset: abort during the 3rd beat's SEND with ready=0.
  - Required: IDLE next cycle, valid=0, no done.
  - Then assert reset low mid-dump: all outputs read 0 immediately.
  - After release, a new start works normally.
- Ignored start: pulse start with first=5 while busy in a 0..3 dump.
  - Required: the dump still ends at addr 3, and no second dump starts.
